// File: rtl/e203_clkgate_ctrl.sv
// e203_clkgate_ctrl
// -----------------
// Per-domain clock-gating controller. It runs on the free-running clock and
// drives the enable pin of the clock-gate cell for one gated unit. After the
// unit has been idle for long enough, it asks the unit for permission to sleep
// using a req/ack handshake, then stops the clock. On a wake demand it turns
// the clock back on and waits a fixed settle window before it reports ready.
//
// Every output comes straight from a flop. This keeps the gate enable free of
// glitches and leaves no combinational path from an input to an output.
//
// Parameters:
//   IDLE_CW      width of the idle threshold and the idle counter
//   WAKE_CYCLES  cycles clock_en is high in WAKE before wake_done (1..15)
//
// Ports:
//   clk          free-running ungated clock
//   rst          asynchronous active-high reset
//   ctrl_en      gating permitted; 0 forces and holds the clock on
//   idle_thresh  idle cycles required beyond the first before a sleep request
//   unit_idle    gated unit reports no work (level)
//   wake_req     pending work for the unit (level)
//   sleep_ack    unit agrees to lose its clock (level, only looked at in SREQ)
//   sleep_req    sleep request/hold to the unit
//   clock_en     enable to the clock-gate cell
//   asleep       high while the clock is stopped
//   wake_done    one-cycle pulse when the clock is stable after a wake
//
// Optional build macro E203_CLKGATE_CTRL_STATS_EN adds:
//   stats_clr     (in)  zeroes sleep_cycles on the next cycle
//   sleep_cycles  (out) saturating count of cycles with clock_en low
module e203_clkgate_ctrl #(
    parameter int IDLE_CW     = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ctrl_en,
    input  logic [IDLE_CW-1:0] idle_thresh,
    input  logic               unit_idle,
    input  logic               wake_req,
    input  logic               sleep_ack,
`ifdef E203_CLKGATE_CTRL_STATS_EN
    input  logic               stats_clr,
`endif
    output logic               sleep_req,
    output logic               clock_en,
    output logic               asleep,
    output logic               wake_done
`ifdef E203_CLKGATE_CTRL_STATS_EN
    ,
    output logic [31:0]        sleep_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SREQ  = 2'd1,
        ST_SLEEP = 2'd2,
        ST_WAKE  = 2'd3
    } state_t;

    localparam logic [3:0] WAKE_LOAD = 4'(WAKE_CYCLES - 1);

    state_t             state;
    state_t             state_nxt;
    logic [IDLE_CW-1:0] idle_cnt;
    logic [IDLE_CW-1:0] idle_nxt;
    logic [3:0]         wake_cnt;
    logic [3:0]         wake_nxt;
    logic               done_nxt;
    logic               qual;
    logic               abort;

    // A qualified idle cycle: the unit is idle, no work is waiting, and
    // gating is allowed. The abort condition pulls the unit back to RUN
    // (from SREQ) or starts a wake (from SLEEP).
    assign qual  = ctrl_en & unit_idle & ~wake_req;
    assign abort = wake_req | ~ctrl_en;

    // Next-state logic. Outside RUN the idle counter is held at zero, so
    // every return to RUN starts a fresh idle streak. In SREQ, an abort is
    // checked before sleep_ack so that a wake demand always wins.
    always_comb begin
        state_nxt = state;
        idle_nxt  = idle_cnt;
        wake_nxt  = wake_cnt;
        done_nxt  = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (qual) begin
                    if (idle_cnt != '1) begin
                        idle_nxt = idle_cnt + 1'b1;
                    end
                    if (idle_cnt >= idle_thresh) begin
                        state_nxt = ST_SREQ;
                    end
                end else begin
                    idle_nxt = '0;
                end
            end
            ST_SREQ: begin
                idle_nxt = '0;
                if (abort) begin
                    state_nxt = ST_RUN;
                end else if (sleep_ack) begin
                    state_nxt = ST_SLEEP;
                end
            end
            ST_SLEEP: begin
                idle_nxt = '0;
                if (abort) begin
                    state_nxt = ST_WAKE;
                    wake_nxt  = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                idle_nxt = '0;
                if (wake_cnt == 4'd0) begin
                    state_nxt = ST_RUN;
                    done_nxt  = 1'b1;
                end else begin
                    wake_nxt = wake_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = ST_RUN;
                idle_nxt  = '0;
            end
        endcase
    end

    // State, counters, and the registered outputs. The outputs are decoded
    // from the next state, so each output flop holds exactly the value that
    // belongs to the state register beside it. Reset turns the clock on at
    // once, without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            idle_cnt  <= '0;
            wake_cnt  <= 4'd0;
            sleep_req <= 1'b0;
            clock_en  <= 1'b1;
            asleep    <= 1'b0;
            wake_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            idle_cnt  <= idle_nxt;
            wake_cnt  <= wake_nxt;
            sleep_req <= (state_nxt != ST_RUN);
            clock_en  <= (state_nxt != ST_SLEEP);
            asleep    <= (state_nxt == ST_SLEEP);
            wake_done <= done_nxt;
        end
    end

`ifdef E203_CLKGATE_CTRL_STATS_EN
    // Counts cycles that had the gate closed. It uses the registered
    // clock_en, so it matches what the gate cell actually saw. A clear takes
    // priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sleep_cycles <= 32'd0;
        end else if (stats_clr) begin
            sleep_cycles <= 32'd0;
        end else if (!clock_en && (sleep_cycles != 32'hFFFF_FFFF)) begin
            sleep_cycles <= sleep_cycles + 32'd1;
        end
    end
`endif

endmodule
